// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan controller for an 8-digit seven-segment display.
// It steps one anode every SCAN_DIV clocks and shows one of four 32-bit
// debug words. The shown word is copied into a snapshot once per frame,
// on the 7 -> 0 digit wrap, so the display never tears mid-scan.
// Optional feature: define SEG_SCAN_LZB_EN to blank leading-zero digits.
// Handshake: there is no valid/ready pair; frame_tick is a one-cycle
// strobe that is high in the cycle the new snapshot and src_idx first
// appear on the outputs.
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 100000,
  parameter int PRE_W    = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] data3,
  input  logic        src_next,
  input  logic        hold,
  output logic [7:0]  AN,
  output logic [3:0]  nibble,
  output logic        blank,
  output logic [1:0]  src_idx,
  output logic        frame_tick
);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [2:0]       digit_q, digit_d;
  logic [1:0]       src_idx_q, src_idx_d;
  logic [1:0]       pend_src_q, pend_src_d;
  logic [31:0]      snap_q, snap_d;
  logic             src_next_dly_q;
  logic             frame_tick_q, frame_tick_d;

  logic             pre_wrap;
  logic             frame_bnd;
  logic             src_rise;
  logic [31:0]      sel_data;
  logic [4:0]       nib_lsb;

  assign pre_wrap  = (pre_q == PRE_W'(SCAN_DIV - 1));
  assign frame_bnd = pre_wrap && (digit_q == 3'd7);
  assign src_rise  = src_next && !src_next_dly_q;
  assign nib_lsb   = {digit_q, 2'b00};

  // Pick the word that the next frame boundary would load.
  always_comb begin
    sel_data = data0;
    case (pend_src_q)
      2'd0:    sel_data = data0;
      2'd1:    sel_data = data1;
      2'd2:    sel_data = data2;
      default: sel_data = data3;
    endcase
  end

  // Next-state: prescaler, digit, pending source and per-frame snapshot.
  always_comb begin
    pre_d        = pre_q + PRE_W'(1);
    digit_d      = digit_q;
    pend_src_d   = pend_src_q;
    src_idx_d    = src_idx_q;
    snap_d       = snap_q;
    frame_tick_d = 1'b0;
    if (pre_wrap) begin
      pre_d   = '0;
      digit_d = digit_q + 3'd1;
    end
    // The boundary loads the pending source as it stood before any
    // edge seen in the same cycle; that edge takes effect next frame.
    if (frame_bnd && !hold) begin
      snap_d       = sel_data;
      src_idx_d    = pend_src_q;
      frame_tick_d = 1'b1;
    end
    if (src_rise) begin
      pend_src_d = pend_src_q + 2'd1;
    end
  end

  // State registers, asynchronously cleared by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q          <= '0;
      digit_q        <= 3'd0;
      src_idx_q      <= 2'd0;
      pend_src_q     <= 2'd0;
      snap_q         <= 32'h0;
      src_next_dly_q <= 1'b0;
      frame_tick_q   <= 1'b0;
    end else begin
      pre_q          <= pre_d;
      digit_q        <= digit_d;
      src_idx_q      <= src_idx_d;
      pend_src_q     <= pend_src_d;
      snap_q         <= snap_d;
      src_next_dly_q <= src_next;
      frame_tick_q   <= frame_tick_d;
    end
  end

`ifdef SEG_SCAN_LZB_EN
  logic [31:0] snap_upper;
  assign snap_upper = snap_q >> nib_lsb;
`endif

  // Display outputs straight from digit and snapshot, no pipeline.
  always_comb begin
    nibble = snap_q[nib_lsb +: 4];
`ifdef SEG_SCAN_LZB_EN
    // Digit 0 always shows, so an all-zero word still reads "0".
    blank = (digit_q != 3'd0) && (snap_upper == 32'h0);
`else
    blank = 1'b0;
`endif
    AN = blank ? 8'hFF : ~(8'b1 << digit_q);
  end

  assign src_idx    = src_idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with SCAN_DIV=4. A reference model counts clock
// edges since reset to know when frames start, and pushes the expected
// load into a queue; a monitor pops it when frame_tick shows and checks
// the scanned digits every cycle.
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int FRAME    = 8 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data0 = 32'h0, data1 = 32'h0, data2 = 32'h0, data3 = 32'h0;
  logic        src_next = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  AN;
  logic [3:0]  nibble;
  logic        blank;
  logic [1:0]  src_idx;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;

  seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .PRE_W(3)) dut (
    .clk(clk), .rst(rst),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .src_next(src_next), .hold(hold),
    .AN(AN), .nibble(nibble), .blank(blank),
    .src_idx(src_idx), .frame_tick(frame_tick)
  );

  // Clock: 10 time units per cycle, rising edges at 5, 15, ...
  always #5 clk = ~clk;

  // Reference model state.
  int          n      = 0;       // rising edges since reset release
  logic [1:0]  m_pend = 2'd0;
  logic [1:0]  m_src  = 2'd0;
  logic [31:0] m_snap = 32'h0;
  logic        m_prev = 1'b0;
  logic [33:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] src_word(input logic [1:0] s);
    case (s)
      2'd0:    return data0;
      2'd1:    return data1;
      2'd2:    return data2;
      default: return data3;
    endcase
  endfunction

  // Model: every FRAME cycles a new frame starts; an unheld boundary loads
  // the pending source, then any rising edge that cycle bumps it.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n = 0; m_pend = 2'd0; m_src = 2'd0; m_snap = 32'h0; m_prev = 1'b0;
      exp_q.delete();
    end else begin
      if ((n % FRAME) == FRAME - 1 && !hold) begin
        m_src  = m_pend;
        m_snap = src_word(m_pend);
        exp_q.push_back({m_pend, m_snap});
      end
      if (src_next && !m_prev) m_pend = m_pend + 2'd1;
      m_prev = src_next;
      n++;
    end
  end

  // Monitor: frame loads come out of the queue, display is checked each cycle.
  always @(negedge clk) begin
    logic [33:0] item;
    int          d;
    logic        e_blank;
    logic [31:0] upper;
    if (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      chk("frame_tick_pulse", {31'h0, frame_tick}, 32'h1);
      chk("src_idx_load", {30'h0, src_idx}, {30'h0, item[33:32]});
      chk("first_nibble", {28'h0, nibble}, {28'h0, item[3:0]});
    end else begin
      chk("frame_tick_idle", {31'h0, frame_tick}, 32'h0);
    end
    d = (n / SCAN_DIV) % 8;
    upper = (d == 0) ? 32'h1 : (m_snap >> (4 * d));
`ifdef SEG_SCAN_LZB_EN
    e_blank = (upper == 32'h0);
`else
    e_blank = 1'b0;
`endif
    chk("AN", {24'h0, AN}, e_blank ? 32'hFF : {24'h0, ~(8'h01 << d)});
    chk("nibble", {28'h0, nibble}, {28'h0, m_snap[4*d +: 4]});
    chk("blank", {31'h0, blank}, {31'h0, e_blank});
    chk("src_idx", {30'h0, src_idx}, {30'h0, m_src});
  end

  // Driver tasks; inputs change on the falling edge.
  task automatic run(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pulse_src(input int hi, input int lo);
    @(negedge clk) src_next = 1'b1;
    run(hi);
    src_next = 1'b0;
    run(lo - 1);
  endtask

  task automatic wait_phase(input int ph);
    int guard = 0;
    @(negedge clk);
    while ((n % FRAME) != ph && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    chk("phase_reached", {31'h0, (n % FRAME) == ph}, 32'h1);
  endtask

  initial begin
    // Reset held for three cycles.
    rst = 1'b0;
    run(3);
    chk("reset_AN", {24'h0, AN}, 32'hFE);
    chk("reset_nibble", {28'h0, nibble}, 32'h0);
    chk("reset_src_idx", {30'h0, src_idx}, 32'h0);
    chk("reset_frame_tick", {31'h0, frame_tick}, 32'h0);
    data0 = 32'h1234_ABCD;
    data1 = 32'h5566_7788;
    data2 = $urandom;
    data3 = $urandom;
    rst = 1'b1;
    run(2 * FRAME + 4);

    // Five source pulses mid-frame leave pend_src at 1.
    wait_phase(3);
    repeat (5) pulse_src(2, 2);
    run(2 * FRAME);

    // Three more pulses bring pend_src back to 0 for the hold test.
    repeat (3) pulse_src(2, 2);
    run(FRAME);
    wait_phase(8);
    hold = 1'b1;
    data0 = 32'hFFFF_FFFF;
    run(FRAME + 8);
    hold = 1'b0;
    run(2 * FRAME);

    // Source edge landing exactly on the wrap cycle.
    wait_phase(FRAME - 1);
    src_next = 1'b1;
    @(negedge clk) src_next = 1'b0;
    run(2 * FRAME + 3);

    // Reset asserted mid-frame, away from a clock edge.
    wait_phase(13);
    #2 rst = 1'b0;
    #1;
    chk("midreset_AN", {24'h0, AN}, 32'hFE);
    chk("midreset_src_idx", {30'h0, src_idx}, 32'h0);
    chk("midreset_nibble", {28'h0, nibble}, 32'h0);
    run(2);
    data0 = 32'h0000_00A5;
    rst = 1'b1;
    run(2 * FRAME);
    data0 = 32'h0;
    run(2 * FRAME);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) src_next = ~src_next;
      if ($urandom_range(0, 30) == 0) hold = ~hold;
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0: data0 = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
          1: data1 = $urandom >> $urandom_range(0, 31);
          2: data2 = $urandom;
          default: data3 = $urandom >> $urandom_range(0, 31);
        endcase
      end
    end

    // Let the last loads drain with hold released.
    hold = 1'b0;
    src_next = 1'b0;
    run(2 * FRAME);
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Scan controller for the 8-digit seven-segment display.
- Time-multiplexes the anodes and selects one of four 32-bit debug sources, e.g. CPU LedData, PC, cycle count, instruction.
- Latches the selected word once per frame so the display never tears mid-scan.
- Drives the anode bus directly and feeds a 4-bit nibble to the existing hex-to-segment pattern decoder.

Parameters:
- SCAN_DIV, 100000, clk cycles each digit stays lit; legal range >= 2.
- PRE_W, 17, width of the prescaler counter; must satisfy 2^PRE_W >= SCAN_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- data0  in  32  display source 0
- data1  in  32  display source 1
- data2  in  32  display source 2
- data3  in  32  display source 3
- src_next  in  1  level from a debounced button; each rising edge advances the source
- hold  in  1  1 = freeze the frame snapshot
- AN  out  8  anode enables, active-low, one-hot-zero
- nibble  out  4  hex digit for the pattern decoder
- blank  out  1  1 = current digit is blanked
- src_idx  out  2  currently displayed source index
- frame_tick  out  1  one-cycle pulse when a new snapshot is loaded

Behaviour:
- Reset (rst=0, asynchronous), all registers take these values:
  - prescaler = 0
  - digit = 0
  - src_idx = 0
  - pend_src = 0
  - snapshot = 32'h0
  - src_next_d = 0
  - frame_tick = 0
- Reset output values: AN=8'hFE, nibble=4'h0, blank=0.
- Prescaler:
  - Increments every clk.
  - When prescaler == SCAN_DIV-1: prescaler <= 0 and digit <= digit+1, wrapping 7 -> 0 (3-bit natural wrap).
- Outputs from digit and snapshot, combinational:
  - AN = ~(8'b1 << digit).
  - nibble = snapshot[4*digit +: 4].
  - Digit 0 is the least significant nibble.
- Frame boundary: the cycle in which digit wraps 7 -> 0.
  - If hold=0: snapshot <= data[pend_src] (value sampled that cycle), src_idx <= pend_src, frame_tick <= 1 for exactly one cycle.
  - If hold=1: snapshot and src_idx are unchanged; frame_tick stays 0; pend_src still accumulates.
- Source select:
  - src_next_d is a 1-cycle delayed copy of src_next.
  - A rising edge (src_next & ~src_next_d) sets pend_src <= pend_src+1, mod 4, wrapping 3 -> 0.
  - The new source becomes visible only at the next non-held frame boundary.
- Simultaneous src_next edge and frame boundary: the boundary loads the OLD pend_src; the increment lands in pend_src the same cycle and is applied at the following frame.
- Changes to data0..3 between frame boundaries have no effect on the outputs.
- Reset asserted mid-frame: all state returns to its reset values immediately. After release, the first snapshot occurs after 8*SCAN_DIV cycles.
- Latency:
  - Display update: <= 8*SCAN_DIV cycles after a source change or data change.
  - AN/nibble change in the same cycle digit changes; no extra pipeline.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - For digit d in 1..7, blank=1 and AN=8'hFF when snapshot[31:4*d] == 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - nibble is still driven normally.
- Undefined: blank is constant 0; all 8 digits always lit.

Test Plan:
- All tests use SCAN_DIV=4.
- Reset: rst=0 for 3 cycles -> AN=8'hFE, nibble=0, src_idx=0, frame_tick=0. After release, AN advances to 8'hFD at cycle 4, then 8'hFB at cycle 8, and so on.
- Frame load: data0=32'h1234_ABCD held; run 32 cycles -> frame_tick pulses once at the 7->0 wrap. Over the next frame nibble reads D,C,B,A,4,3,2,1 with AN=FE,FD,FB,F7,EF,DF,BF,7F.
- Source cycling: pulse src_next 5 times mid-frame (each high 2 cycles, low 2 cycles) -> pend_src=1 (5 mod 4). src_idx stays 0 until the wrap, then becomes 1 and the snapshot equals data1.
- Hold and tear-free: hold=1 across a wrap while data0 changes to 32'hFFFF_FFFF -> snapshot keeps 32'h1234_ABCD, no frame_tick. Release hold -> the next wrap loads 32'hFFFF_FFFF.
- Simultaneous edge and wrap: src_next rising in the wrap cycle -> that frame loads the old source; the next frame loads the new one.
- SEG_SCAN_LZB_EN defined, data0=32'h0000_00A5 -> digits 2..7 show AN=8'hFF with blank=1, digits 0..1 lit. data0=0 -> only digit 0 lit, showing 0.
